// File: rtl/pilot_gen_param_wifi.sv
// Pilot-subcarrier generator: per-symbol pilot values from a base sign
// pattern times the 127-periodic x^7+x^4+1 polarity sequence.
// Optional seed-load port pair is built when PILOT_SEED_LOAD_EN is defined.
//
// Ports:
//   clk, reset (async, active-low), enable (global advance enable)
//   frame_start  : restart polarity sequence at index 0, abort symbol
//   sym_start    : request one symbol of NUM_PILOTS pilots
//   out_ready    : downstream ready
//   valid_out, data_out, pilot_idx, sym_idx, last_out : registered output
//   seed_load, seed_in (PILOT_SEED_LOAD_EN only) : load LFSR seed in IDLE
module pilot_gen_param_wifi #(
    parameter int              DATA_W        = 12,
    parameter int              FRAC_W        = 9,
    parameter int              NUM_PILOTS    = 4,
    parameter logic [15:0]     PILOT_PATTERN = 16'h0008,
    parameter logic [6:0]      POLARITY_INIT = 7'h7F
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    input  logic              frame_start,
    input  logic              sym_start,
    input  logic              out_ready,
`ifdef PILOT_SEED_LOAD_EN
    input  logic              seed_load,
    input  logic [6:0]        seed_in,
`endif
    output logic              valid_out,
    output logic [DATA_W-1:0] data_out,
    output logic [3:0]        pilot_idx,
    output logic [6:0]        sym_idx,
    output logic              last_out
);

    typedef enum logic {
        IDLE = 1'b0,
        EMIT = 1'b1
    } state_t;

    localparam logic [DATA_W-1:0] MAG      = DATA_W'(1) << FRAC_W;
    localparam logic [DATA_W-1:0] NEG_MAG  = ~MAG + 1'b1;
    localparam logic [3:0]        LAST_IDX = 4'(NUM_PILOTS - 1);
    localparam logic              ONE_PIL  = (LAST_IDX == 4'd0);

    state_t              state_q, state_d;
    logic [6:0]          lfsr_q, lfsr_d;
    logic [6:0]          sym_q, sym_d;
    logic [3:0]          pidx_q, pidx_d;
    logic                valid_q, valid_d;
    logic                last_q, last_d;
    logic [DATA_W-1:0]   data_q, data_d;

    logic                fb_q;
    logic [6:0]          lfsr_adv;
    logic [6:0]          sym_inc;
    logic [3:0]          pidx_inc;

    // Polarity of a symbol is the feedback bit of the LFSR state it uses.
    function automatic logic [DATA_W-1:0] pilot_val(
        input logic [3:0] idx,
        input logic [6:0] l
    );
        logic neg;
        neg = PILOT_PATTERN[idx] ^ (l[6] ^ l[3]);
        return neg ? NEG_MAG : MAG;
    endfunction

    assign fb_q     = lfsr_q[6] ^ lfsr_q[3];
    assign lfsr_adv = {lfsr_q[5:0], fb_q};
    assign sym_inc  = (sym_q == 7'd126) ? 7'd0 : sym_q + 7'd1;
    assign pidx_inc = pidx_q + 4'd1;

    always_comb begin
        state_d = state_q;
        lfsr_d  = lfsr_q;
        sym_d   = sym_q;
        pidx_d  = pidx_q;
        valid_d = valid_q;
        last_d  = last_q;
        data_d  = data_q;
        if (enable) begin
            if (frame_start) begin
                lfsr_d  = POLARITY_INIT;
                sym_d   = 7'd0;
                pidx_d  = 4'd0;
                state_d = IDLE;
                valid_d = 1'b0;
                last_d  = 1'b0;
            end else begin
                unique case (state_q)
                    IDLE: begin
`ifdef PILOT_SEED_LOAD_EN
                        if (seed_load) begin
                            // An all-zero seed would lock the LFSR.
                            lfsr_d = (seed_in == 7'd0) ? POLARITY_INIT
                                                       : seed_in;
                            sym_d  = 7'd0;
                        end
`endif
                        if (sym_start) begin
                            state_d = EMIT;
                            valid_d = 1'b1;
                            pidx_d  = 4'd0;
                            last_d  = ONE_PIL;
                            data_d  = pilot_val(4'd0, lfsr_d);
                        end
                    end
                    EMIT: begin
                        if (valid_q && out_ready) begin
                            if (last_q) begin
                                lfsr_d = lfsr_adv;
                                sym_d  = sym_inc;
                                pidx_d = 4'd0;
                                if (sym_start) begin
                                    valid_d = 1'b1;
                                    last_d  = ONE_PIL;
                                    data_d  = pilot_val(4'd0, lfsr_adv);
                                end else begin
                                    state_d = IDLE;
                                    valid_d = 1'b0;
                                    last_d  = 1'b0;
                                end
                            end else begin
                                pidx_d = pidx_inc;
                                last_d = (pidx_inc == LAST_IDX);
                                data_d = pilot_val(pidx_inc, lfsr_q);
                            end
                        end
                    end
                    default: begin
                        state_d = IDLE;
                    end
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            lfsr_q  <= POLARITY_INIT;
            sym_q   <= 7'd0;
            pidx_q  <= 4'd0;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            lfsr_q  <= lfsr_d;
            sym_q   <= sym_d;
            pidx_q  <= pidx_d;
            valid_q <= valid_d;
            last_q  <= last_d;
            data_q  <= data_d;
        end
    end

    assign valid_out = valid_q;
    assign data_out  = data_q;
    assign pilot_idx = pidx_q;
    assign sym_idx   = sym_q;
    assign last_out  = last_q;

endmodule

// File: tb/tb_pilot_gen_param_wifi.sv
// Bench for pilot_gen_param_wifi: scoreboard of expected pilots,
// filled from a software LFSR model when symbols are requested.
module tb_pilot_gen_param_wifi;

    logic        clk;
    logic        reset;
    logic        enable;
    logic        frame_start;
    logic        sym_start;
    logic        out_ready;
`ifdef PILOT_SEED_LOAD_EN
    logic        seed_load;
    logic [6:0]  seed_in;
`endif
    logic        valid_out;
    logic [11:0] data_out;
    logic [3:0]  pilot_idx;
    logic [6:0]  sym_idx;
    logic        last_out;

    int vec;
    int err;

    logic [23:0] q[$];
    logic [6:0]  m_lfsr;
    logic [6:0]  m_sym;

    localparam logic [15:0] PAT = 16'h0008;

    pilot_gen_param_wifi dut (
        .clk         (clk),
        .reset       (reset),
        .enable      (enable),
        .frame_start (frame_start),
        .sym_start   (sym_start),
        .out_ready   (out_ready),
`ifdef PILOT_SEED_LOAD_EN
        .seed_load   (seed_load),
        .seed_in     (seed_in),
`endif
        .valid_out   (valid_out),
        .data_out    (data_out),
        .pilot_idx   (pilot_idx),
        .sym_idx     (sym_idx),
        .last_out    (last_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        vec++;
        assert (obs === exp) else begin
            err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Queue one symbol of expected pilots, then advance the model.
    task automatic push_sym();
        logic fb;
        logic neg;
        fb = m_lfsr[6] ^ m_lfsr[3];
        for (int i = 0; i < 4; i++) begin
            neg = PAT[i] ^ fb;
            q.push_back({neg ? 12'hE00 : 12'h200, 4'(i), m_sym, i == 3});
        end
        m_lfsr = {m_lfsr[5:0], fb};
        m_sym  = (m_sym == 7'd126) ? 7'd0 : m_sym + 7'd1;
    endtask

    task automatic model_reset();
        q.delete();
        m_lfsr = 7'h7F;
        m_sym  = 7'd0;
    endtask

    // One cycle: compare any pilot that transfers at the coming edge.
    task automatic tick();
        logic [23:0] e;
        @(negedge clk);
        if (reset && enable && out_ready && valid_out && !frame_start) begin
            chk("sb_nonempty", 32'(q.size() != 0), 1);
            if (q.size() != 0) begin
                e = q.pop_front();
                chk("pilot", {8'd0, data_out, pilot_idx, sym_idx, last_out},
                    {8'd0, e});
            end
        end
        @(posedge clk);
        #1;
    endtask

    // n symbols back-to-back, sym_start raised on each last transfer.
    task automatic run(input int n);
        sym_start = 1'b1;
        push_sym();
        tick();
        for (int k = 0; k < n; k++) begin
            for (int j = 0; j < 4; j++) begin
                if (j == 3 && k < n - 1) begin
                    sym_start = 1'b1;
                    push_sym();
                end else begin
                    sym_start = 1'b0;
                end
                tick();
                if (!(k == n - 1 && j == 3))
                    chk("no_bubble", 32'(valid_out), 1);
            end
        end
        sym_start = 1'b0;
    endtask

    initial begin
        vec = 0;
        err = 0;
        reset = 1'b0;
        enable = 1'b0;
        frame_start = 1'b0;
        sym_start = 1'b0;
        out_ready = 1'b0;
`ifdef PILOT_SEED_LOAD_EN
        seed_load = 1'b0;
        seed_in = 7'd0;
`endif
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        chk("rst_valid", 32'(valid_out), 0);
        chk("rst_data", 32'(data_out), 0);
        chk("rst_pidx", 32'(pilot_idx), 0);
        chk("rst_sym", 32'(sym_idx), 0);
        chk("rst_last", 32'(last_out), 0);
        reset = 1'b1;
        enable = 1'b1;
        out_ready = 1'b1;
        tick();

        // First symbol, latency one edge.
        sym_start = 1'b1;
        push_sym();
        tick();
        sym_start = 1'b0;
        chk("lat_valid", 32'(valid_out), 1);
        chk("lat_data", 32'(data_out), 32'h200);
        repeat (4) tick();
        chk("sym0_done_valid", 32'(valid_out), 0);
        chk("sym0_done_idx", 32'(sym_idx), 1);

        // Symbols 1..4 back-to-back.
        run(4);
        tick();

        // Up to symbol 126, then wrap.
        run(122);
        chk("wrap_sym", 32'(sym_idx), 0);
        chk("wrap_lfsr", 32'(dut.lfsr_q), 32'h7F);
        run(1);

        // Backpressure and enable stall during pilot 2.
        sym_start = 1'b1;
        push_sym();
        tick();
        sym_start = 1'b0;
        tick();
        tick();
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("bp_data", 32'(data_out), 32'(q[0][23:12]));
            chk("bp_pidx", 32'(pilot_idx), 2);
        end
        out_ready = 1'b1;
        enable = 1'b0;
        for (int i = 0; i < 2; i++) begin
            tick();
            chk("en_data", 32'(data_out), 32'(q[0][23:12]));
            chk("en_pidx", 32'(pilot_idx), 2);
        end
        enable = 1'b1;
        tick();
        tick();
        chk("bp_drained", 32'(q.size()), 0);

        // frame_start during pilot 1 of symbol 10.
        run(8);
        chk("pre_frame_sym", 32'(sym_idx), 10);
        sym_start = 1'b1;
        push_sym();
        tick();
        sym_start = 1'b0;
        tick();
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        chk("fs_valid", 32'(valid_out), 0);
        chk("fs_sym", 32'(sym_idx), 0);
        chk("fs_pidx", 32'(pilot_idx), 0);
        model_reset();
        run(1);

        // Asynchronous reset mid-symbol.
        sym_start = 1'b1;
        push_sym();
        tick();
        sym_start = 1'b0;
        tick();
        #2;
        reset = 1'b0;
        #1;
        chk("arst_valid", 32'(valid_out), 0);
        chk("arst_data", 32'(data_out), 0);
        chk("arst_pidx", 32'(pilot_idx), 0);
        chk("arst_sym", 32'(sym_idx), 0);
        chk("arst_last", 32'(last_out), 0);
        model_reset();
        tick();
        reset = 1'b1;
        tick();
        run(2);

`ifdef PILOT_SEED_LOAD_EN
        tick();
        seed_load = 1'b1;
        seed_in = 7'h01;
        tick();
        seed_load = 1'b0;
        m_lfsr = 7'h01;
        m_sym = 7'd0;
        chk("seed_sym", 32'(sym_idx), 0);
        run(3);
        tick();
        seed_load = 1'b1;
        seed_in = 7'h00;
        tick();
        seed_load = 1'b0;
        m_lfsr = 7'h7F;
        m_sym = 7'd0;
        run(2);
`endif

        for (int i = 0; i < 20 && q.size() != 0; i++) tick();
        chk("final_drain", 32'(q.size()), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vec, err);
        $finish;
    end

endmodule
